// File: rtl/serial_denormalizer.sv
// Multi-cycle logical right-shift denormalizer: a nibble per cycle while 4 or more positions remain, then a bit per cycle.
// Shifted-out bits fold into sticky_o. Define DENORM_ROUND_BITS_EN to add separate guard_o/round_o outputs. DATA_WIDTH must be 32 or 24.
module serial_denormalizer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [DATA_WIDTH-1:0]         operand_i,
  input  logic [$clog2(DATA_WIDTH):0]   shift_amt_i,
  output logic [DATA_WIDTH-1:0]         result_o,
  output logic                          sticky_o,
`ifdef DENORM_ROUND_BITS_EN
  output logic                          guard_o,
  output logic                          round_o,
`endif
  output logic                          valid_o,
  input  logic                          ready_i
);

  localparam int SW = $clog2(DATA_WIDTH) + 1;
  localparam logic [SW-1:0] MAX_AMT = SW'(DATA_WIDTH);
  localparam logic [SW-1:0] NIBBLE  = SW'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [SW-1:0]           rem_q, rem_d;
  logic                    sticky_q, sticky_d;
  logic [SW-1:0]           sat_amt;
`ifdef DENORM_ROUND_BITS_EN
  logic                    guard_q, guard_d;
  logic                    round_q, round_d;
`endif

  // Amounts beyond the operand width behave exactly like a full-width shift.
  assign sat_amt = (shift_amt_i > MAX_AMT) ? MAX_AMT : shift_amt_i;

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rem_d    = rem_q;
    sticky_d = sticky_q;
`ifdef DENORM_ROUND_BITS_EN
    guard_d  = guard_q;
    round_d  = round_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          data_d   = operand_i;
          rem_d    = sat_amt;
          sticky_d = 1'b0;
`ifdef DENORM_ROUND_BITS_EN
          guard_d  = 1'b0;
          round_d  = 1'b0;
`endif
          state_d  = (sat_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (rem_q >= NIBBLE) begin
          data_d   = data_q >> 4;
          rem_d    = rem_q - NIBBLE;
`ifdef DENORM_ROUND_BITS_EN
          guard_d  = data_q[3];
          round_d  = data_q[2];
          sticky_d = sticky_q | (|data_q[1:0]) | guard_q | round_q;
`else
          sticky_d = sticky_q | (|data_q[3:0]);
`endif
        end else begin
          data_d   = data_q >> 1;
          rem_d    = rem_q - SW'(1);
`ifdef DENORM_ROUND_BITS_EN
          guard_d  = data_q[0];
          round_d  = guard_q;
          sticky_d = sticky_q | round_q;
`else
          sticky_d = sticky_q | data_q[0];
`endif
        end
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments only; the async reset clears the datapath too, so outputs read 0 right away.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      data_q   <= '0;
      rem_q    <= '0;
      sticky_q <= 1'b0;
`ifdef DENORM_ROUND_BITS_EN
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      sticky_q <= sticky_d;
`ifdef DENORM_ROUND_BITS_EN
      guard_q  <= guard_d;
      round_q  <= round_d;
`endif
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = data_q;
  assign sticky_o = sticky_q;
`ifdef DENORM_ROUND_BITS_EN
  assign guard_o  = guard_q;
  assign round_o  = round_q;
`endif

endmodule

// File: tb/tb_serial_denormalizer.sv
// Self-checking bench for serial_denormalizer: directed cases plus randomized requests checked against a positional model.
// A separate compare process checks every cycle in which valid_o is high.
module tb_serial_denormalizer;

  localparam int DW = 32;
  localparam int SW = $clog2(DW) + 1;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] operand_i;
  logic [SW-1:0] shift_amt_i;
  logic [DW-1:0] result_o;
  logic          sticky_o;
  logic          valid_o;
  logic          ready_i;
`ifdef DENORM_ROUND_BITS_EN
  logic          guard_o;
  logic          round_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs of the request currently in flight.
  logic [DW-1:0] exp_res;
  logic          exp_sticky;
  logic          exp_guard;
  logic          exp_round;
  int            exp_edges;

  serial_denormalizer #(.DATA_WIDTH(DW)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .operand_i   (operand_i),
    .shift_amt_i (shift_amt_i),
    .result_o    (result_o),
    .sticky_o    (sticky_o),
`ifdef DENORM_ROUND_BITS_EN
    .guard_o     (guard_o),
    .round_o     (round_o),
`endif
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Positional view: the result is op >> s, the shifted-out bits are op[s-1:0].
  task automatic model(input logic [DW-1:0] op, input logic [SW-1:0] amt,
                       output logic [DW-1:0] res, output logic st,
                       output logic g, output logic r, output int edges);
    int          s;
    logic [63:0] out_bits;
    s        = (int'(amt) > DW) ? DW : int'(amt);
    res      = op >> s;
    out_bits = {32'd0, op} & ((64'd1 << s) - 64'd1);
    edges    = s / 4 + s % 4;
    g        = (s >= 1) ? out_bits[s-1] : 1'b0;
    r        = (s >= 2) ? out_bits[s-2] : 1'b0;
`ifdef DENORM_ROUND_BITS_EN
    st       = (s >= 3) ? |(out_bits & ((64'd1 << (s - 2)) - 64'd1)) : 1'b0;
`else
    st       = |out_bits;
`endif
  endtask

  // Compare process: every cycle the result is presented it must match the model.
  always @(negedge clk_i) begin
    if (rst_n_i === 1'b1 && valid_o === 1'b1) begin
      check("done_result", 64'(result_o), 64'(exp_res));
      check("done_sticky", 64'(sticky_o), 64'(exp_sticky));
      check("done_ready_low", 64'(ready_o), 64'd0);
`ifdef DENORM_ROUND_BITS_EN
      check("done_guard", 64'(guard_o), 64'(exp_guard));
      check("done_round", 64'(round_o), 64'(exp_round));
`endif
    end
  end

  task automatic run_txn(input logic [DW-1:0] op, input logic [SW-1:0] amt, input int hold);
    int            edges;
    logic [DW-1:0] held_res;
    logic          held_st;
    model(op, amt, exp_res, exp_sticky, exp_guard, exp_round, exp_edges);
    @(negedge clk_i);
    check("ready_in_idle", 64'(ready_o), 64'd1);
    valid_i     = 1'b1;
    operand_i   = op;
    shift_amt_i = amt;
    @(posedge clk_i); #1;
    valid_i     = 1'b0;
    operand_i   = DW'($urandom);
    shift_amt_i = SW'($urandom);
    edges = 0;
    while (valid_o !== 1'b1 && edges < 64) begin
      @(posedge clk_i); #1;
      edges++;
    end
    check("latency_edges", 64'(edges), 64'(exp_edges));
    held_res = result_o;
    held_st  = sticky_o;
    for (int k = 0; k < hold; k++) begin
      check("hold_ready_low", 64'(ready_o), 64'd0);
      valid_i     = 1'b1;
      operand_i   = DW'($urandom);
      shift_amt_i = SW'($urandom);
      @(posedge clk_i); #1;
      check("hold_valid", 64'(valid_o), 64'd1);
      check("hold_result", 64'(result_o), 64'(held_res));
      check("hold_sticky", 64'(sticky_o), 64'(held_st));
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check("release_valid_low", 64'(valid_o), 64'd0);
    check("release_ready_high", 64'(ready_o), 64'd1);
    check("idle_keeps_result", 64'(result_o), 64'(exp_res));
    check("idle_keeps_sticky", 64'(sticky_o), 64'(exp_sticky));
  endtask

  initial begin
    rst_n_i     = 1'b0;
    valid_i     = 1'b0;
    ready_i     = 1'b0;
    operand_i   = '0;
    shift_amt_i = '0;
    exp_res     = '0;
    exp_sticky  = 1'b0;
    exp_guard   = 1'b0;
    exp_round   = 1'b0;
    exp_edges   = 0;
    #1;
    check("reset_ready", 64'(ready_o), 64'd1);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_result", 64'(result_o), 64'd0);
    check("reset_sticky", 64'(sticky_o), 64'd0);
    #13;
    rst_n_i = 1'b1;

    // Directed cases with hand-computed expectations pinning the model.
    run_txn(32'hF000_0001, SW'(0), 0);
    check("t1_result", 64'(result_o), 64'hF000_0001);
    check("t1_sticky", 64'(sticky_o), 64'd0);
    check("t1_edges", 64'(exp_edges), 64'd0);

    run_txn(32'h8000_0000, SW'(5), 0);
    check("t2_result", 64'(result_o), 64'h0400_0000);
    check("t2_sticky", 64'(sticky_o), 64'd0);
    check("t2_edges", 64'(exp_edges), 64'd2);

    run_txn(32'h0000_00FF, SW'(7), 0);
    check("t3_result", 64'(result_o), 64'h1);
    check("t3_sticky", 64'(sticky_o), 64'd1);
    check("t3_edges", 64'(exp_edges), 64'd4);
`ifdef DENORM_ROUND_BITS_EN
    check("t3_guard", 64'(guard_o), 64'd1);
    check("t3_round", 64'(round_o), 64'd1);
`endif

    run_txn(32'h0000_0001, SW'(40), 0);
    check("t4_result", 64'(result_o), 64'd0);
    check("t4_sticky", 64'(sticky_o), 64'd1);
    check("t4_edges", 64'(exp_edges), 64'd8);

    // Backpressure: three stalled cycles with a competing request on valid_i.
    run_txn(32'hDEAD_BEEF, SW'(13), 3);
    check("t5_result", 64'(result_o), 64'h0006_F56D);
    check("t5_sticky", 64'(sticky_o), 64'd1);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk_i);
    valid_i     = 1'b1;
    operand_i   = 32'hFFFF_FFFF;
    shift_amt_i = SW'(20);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #2;
    check("mid_shift_result_nonzero", 64'(result_o != '0), 64'd1);
    rst_n_i = 1'b0;
    #1;
    check("async_rst_valid", 64'(valid_o), 64'd0);
    check("async_rst_result", 64'(result_o), 64'd0);
    check("async_rst_sticky", 64'(sticky_o), 64'd0);
    check("async_rst_ready", 64'(ready_o), 64'd1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_txn(32'h1234_5678, SW'(9), 1);

    // Randomized requests, including saturating amounts and random stalls.
    for (int i = 0; i < 150; i++) begin
      run_txn(DW'($urandom), SW'($urandom_range(0, (1 << SW) - 1)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
